// File: rtl/mul4_shift_add_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
// Imported by the multiplier top and its handshake interface.
package mul_pkg;

  localparam int MUL_N = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/mul4_shift_add_if.sv
// Operand/result handshake between control logic and the multiplier.
// The master issues operands; the slave computes the product.
interface mul4_shift_add_if #(
  parameter int N = mul_pkg::MUL_N
);

  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*N-1:0] p;

  modport master (
    output start,
    output a,
    output b,
    input  ready,
    input  busy,
    input  done,
    input  p
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output ready,
    output busy,
    output done,
    output p
  );

endinterface

// File: rtl/mul4_shift_add_addn_rc.sv
// N-bit ripple-carry adder built from 1-bit full-adder cells.
// Used as the partial-product adder of the multiplier.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

module addn_rc #(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;
  assign cout = c[N];

  for (genvar i = 0; i < N; i++) begin : g_bit
    fa_cell u_fa (
      .x  (x[i]),
      .y  (y[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

endmodule

// File: rtl/mul4_shift_add.sv
// Sequential unsigned shift-and-add multiplier, one partial
// product per clock, with a start/ready/done handshake.
module mul4_shift_add
  import mul_pkg::*;
#(
  parameter int N = MUL_N
) (
  input  logic            clk,
  input  logic            rst_n,
  mul4_shift_add_if.slave bus
);

  localparam int CW = clog2(N + 1);

  state_t         state;
  logic [N-1:0]   mcand;
  logic [2*N-1:0] prod;
  logic [2*N-1:0] prod_nxt;
  logic [2*N-1:0] p_q;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   sum;
  logic           co;
  logic [N:0]     hi;

  addn_rc #(.N(N)) u_add (
    .x    (prod[2*N-1:N]),
    .y    (mcand),
    .cin  (1'b0),
    .s    (sum),
    .cout (co)
  );

  // Carry-out lands in the MSB as the register shifts right.
  always_comb begin
    hi       = prod[0] ? {co, sum} : {1'b0, prod[2*N-1:N]};
    prod_nxt = {hi, prod[N-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      mcand <= '0;
      prod  <= '0;
      cnt   <= '0;
      p_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            mcand <= bus.a;
            prod  <= {{N{1'b0}}, bus.b};
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          prod <= prod_nxt;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            p_q   <= prod_nxt;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.busy  = (state == RUN) || (state == DONE);
  assign bus.done  = (state == DONE);
  assign bus.p     = p_q;

endmodule

// File: tb/tb_mul4_shift_add.sv
// Self-checking bench for mul4_shift_add against a plain a*b
// reference with latency/throughput expectations.
module tb_mul4_shift_add;

  localparam int N  = 4;
  localparam int LAT = N + 1;
  localparam int PER = N + 2;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   dones;

  mul4_shift_add_if #(.N(N)) bus ();

  mul4_shift_add #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && bus.done) dones++;

  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [2*N-1:0] exp;
    int lat;
    bit seen;
    exp = {{N{1'b0}}, x} * {{N{1'b0}}, y};
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL op_ready a=%h b=%h got=%b exp=1", x, y, bus.ready);
    end
    bus.start = 1'b1;
    bus.a = x;
    bus.b = y;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = N'($urandom);
    bus.b = N'($urandom);
    lat = 1;
    seen = 0;
    while (!seen && lat < 4 * N) begin
      if (bus.done === 1'b1) seen = 1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    checks++;
    if (!seen || lat != LAT) begin
      errors++;
      $display("FAIL op_latency a=%h b=%h got=%0d seen=%0b exp=%0d",
               x, y, lat, seen, LAT);
    end
    checks++;
    if (bus.p !== exp) begin
      errors++;
      $display("FAIL op_product a=%h b=%h got=%h exp=%h", x, y, bus.p, exp);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.p !== exp) begin
      errors++;
      $display("FAIL op_after a=%h b=%h done=%b ready=%b p=%h exp_p=%h",
               x, y, bus.done, bus.ready, bus.p, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.p !== '0) begin
      errors++;
      $display("FAIL reset_state ready=%b busy=%b done=%b p=%h exp=1/0/0/00",
               bus.ready, bus.busy, bus.done, bus.p);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int d0;
    d0 = dones;
    run_op(4'hF, 4'hF);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1 || bus.p !== 8'hE1 || dones != d0 + 1) begin
      errors++;
      $display("FAIL basic_hold ready=%b p=%h dones=%0d exp=1/e1/%0d",
               bus.ready, bus.p, dones - d0, 1);
    end
    run_op(4'h5, 4'h3);
    run_op(4'h0, 4'hA);
    run_op(4'h9, 4'h0);
    checks++;
    if (dones != d0 + 4) begin
      errors++;
      $display("FAIL basic_done_count got=%0d exp=4", dones - d0);
    end
  endtask

  task automatic test_start_while_busy();
    int d0;
    int k;
    @(negedge clk);
    d0 = dones;
    bus.start = 1'b1;
    bus.a = 4'h7;
    bus.b = 4'h6;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 4'h1;
    bus.b = 4'h1;
    checks++;
    if (bus.ready !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_ready got ready=%b busy=%b exp=0/1",
               bus.ready, bus.busy);
    end
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (bus.done !== 1'b1 && k < 4 * N) begin
      checks++;
      if (bus.ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_ready_low got=%b exp=0", bus.ready);
      end
      @(negedge clk);
      k++;
    end
    checks++;
    if (bus.done !== 1'b1 || bus.p !== 8'h2A) begin
      errors++;
      $display("FAIL busy_product done=%b p=%h exp=1/2a", bus.done, bus.p);
    end
    repeat (PER) @(negedge clk);
    checks++;
    if (dones != d0 + 1 || bus.p !== 8'h2A || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_ignored dones=%0d p=%h ready=%b exp=1/2a/1",
               dones - d0, bus.p, bus.ready);
    end
  endtask

  task automatic test_reset_abort();
    int d0;
    @(negedge clk);
    d0 = dones;
    bus.start = 1'b1;
    bus.a = 4'hC;
    bus.b = 4'hB;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.p !== '0) begin
      errors++;
      $display("FAIL abort_state ready=%b busy=%b done=%b p=%h exp=1/0/0/00",
               bus.ready, bus.busy, bus.done, bus.p);
    end
    rst_n = 1'b1;
    repeat (PER) @(negedge clk);
    checks++;
    if (dones != d0) begin
      errors++;
      $display("FAIL abort_no_done got=%0d exp=0", dones - d0);
    end
    run_op(4'h2, 4'h3);
  endtask

  task automatic test_back_to_back();
    localparam int OPS = 5;
    logic [2*N-1:0] q[$];
    logic [2*N-1:0] exp;
    logic [N-1:0] x;
    logic [N-1:0] y;
    bit want;
    int d0;
    @(negedge clk);
    d0 = dones;
    for (int k = 0; k < OPS * PER + PER; k++) begin
      want = (k >= LAT) && ((k - LAT) % PER == 0) && ((k - LAT) / PER < OPS);
      checks++;
      if (bus.done !== want) begin
        errors++;
        $display("FAIL b2b_done k=%0d got=%b exp=%b", k, bus.done, want);
      end
      if (want && q.size() > 0) begin
        exp = q.pop_front();
        checks++;
        if (bus.p !== exp) begin
          errors++;
          $display("FAIL b2b_product k=%0d got=%h exp=%h", k, bus.p, exp);
        end
      end
      if (k < OPS * PER) begin
        x = N'($urandom);
        y = N'($urandom);
        bus.start = 1'b1;
        bus.a = x;
        bus.b = y;
        if (k % PER == 0) q.push_back({{N{1'b0}}, x} * {{N{1'b0}}, y});
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (dones != d0 + OPS) begin
      errors++;
      $display("FAIL b2b_count got=%0d exp=%0d", dones - d0, OPS);
    end
  endtask

  task automatic test_sweep();
    int d0;
    d0 = dones;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        run_op(N'(i), N'(j));
    checks++;
    if (dones != d0 + 256) begin
      errors++;
      $display("FAIL sweep_count got=%0d exp=256", dones - d0);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    dones  = 0;
    test_reset();
    test_basic();
    test_start_while_busy();
    test_reset_abort();
    test_back_to_back();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
